// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM states, countdown width and the alignment check.
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // funct3[1:0] is log2 of the access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] lane);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return |lane[1:0];
            default: return |lane;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension and
// store byte-merge into the existing 64-bit word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  lane,
    input  logic [63:0] mem_word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] wdata_shifted;
    logic [63:0] bit_mask;
    logic [7:0]  byte_mask;

    assign shamt         = {lane, 3'b000};
    assign shifted       = mem_word >> shamt;
    assign wdata_shifted = wdata << shamt;

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {56'b0, shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {48'b0, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_WU:   load_data = {32'b0, shifted[31:0]};
            F3_D:    load_data = shifted;
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        byte_mask = 8'hFF;
        case (funct3[1:0])
            2'b00:   byte_mask = 8'h01 << lane;
            2'b01:   byte_mask = 8'h03 << lane;
            2'b10:   byte_mask = 8'h0F << lane;
            default: byte_mask = 8'hFF;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign bit_mask[gi*8 +: 8] = {8{byte_mask[gi]}};
        end
    endgenerate

    assign store_word = (mem_word & ~bit_mask) | (wdata_shifted & bit_mask);

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// The word is read at acceptance and written back (merged) at commit.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               write_reg;
    logic [2:0]         funct3_reg;
    logic [63:0]        addr_reg;
    logic [63:0]        wdata_reg;
    logic [63:0]        rd_word_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic [63:0]        rsp_rdata_reg;
    logic               rsp_err_reg;

    logic [63:0] mem [DEPTH] = '{default: '0};

    logic             accept;
    logic             commit;
    logic             req_in_range;
    logic             access_err;
    logic             illegal_f3;
    logic             mem_we;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      load_data;
    logic [63:0]      store_word;

    assign accept       = req_valid & req_ready_reg;
    assign commit       = (state_reg == BUSY) && (count_reg == '0);
    assign req_idx      = req_addr[3 +: IDX_W];
    assign wr_idx       = addr_reg[3 +: IDX_W];
    assign req_in_range = req_addr[63:3] < 61'(DEPTH);
    assign illegal_f3   = write_reg ? funct3_reg[2] : (funct3_reg == 3'b111);
    assign access_err   = misaligned(funct3_reg, addr_reg[2:0])
                        | (addr_reg[63:3] >= 61'(DEPTH))
                        | illegal_f3;
    assign mem_we       = commit & write_reg & ~access_err;

    dmem_lane_align u_align (
        .funct3     (funct3_reg),
        .lane       (addr_reg[2:0]),
        .mem_word   (rd_word_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Only one request is in flight, so the word read at acceptance is
    // still current when the merged store is written back at commit.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_idx] <= store_word;
        if (accept && req_in_range)
            rd_word_reg <= mem[req_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            write_reg     <= 1'b0;
            funct3_reg    <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        write_reg     <= req_write;
                        funct3_reg    <= req_funct3;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        count_reg     <= CNT_INIT;
                        req_ready_reg <= 1'b0;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_reg == '0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= access_err;
                        rsp_rdata_reg <= (access_err || write_reg) ? 64'd0 : load_data;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
